// File: rtl/shft_flag_reg.sv
// Shifter writeback stage: one-entry result buffer plus the flag register, latency 1 cycle.
// Backpressure: shft_rdy drops only while a buffered result is held (wb_vld & !wb_rdy).
module shft_flag_reg (
  input  logic       clkc,
  input  logic       reset,
  input  logic       shft_vld,
  output logic       shft_rdy,
  input  logic [7:0] shft_out,
  input  logic       shft_c,
  input  logic       acc_op,
  input  logic       flg_ld,
  input  logic [7:0] flg_in,
  output logic       wb_vld,
  input  logic       wb_rdy,
  output logic [7:0] wb_data,
  output logic [7:0] flag_reg,
  output logic       carry_bit
);

  logic       accept;
  logic [7:0] nxt_flags;
  logic       nxt_s;
  logic       nxt_z;
  logic       nxt_p;

  assign shft_rdy  = !wb_vld | wb_rdy;
  assign accept    = shft_vld & shft_rdy;
  assign carry_bit = flag_reg[0];

  // Accumulator rotates keep S, Z and P from the previous flag state.
  always_comb begin
    nxt_s = shft_out[7];
    nxt_z = (shft_out == 8'h00);
    nxt_p = ~^shft_out;
    if (acc_op) begin
      nxt_s = flag_reg[7];
      nxt_z = flag_reg[6];
      nxt_p = flag_reg[2];
    end
    nxt_flags = {nxt_s, nxt_z, shft_out[5], 1'b0, shft_out[3], nxt_p, 1'b0, shft_c};
  end

  always_ff @(posedge clkc) begin
    if (reset) begin
      wb_vld   <= 1'b0;
      wb_data  <= 8'h00;
      flag_reg <= 8'h00;
    end else begin
      if (accept) begin
        wb_vld  <= 1'b1;
        wb_data <= shft_out;
      end else if (wb_vld && wb_rdy) begin
        wb_vld  <= 1'b0;
      end

      if (flg_ld) begin
        flag_reg <= flg_in;
      end else if (accept) begin
        flag_reg <= nxt_flags;
      end
    end
  end

endmodule
